// File: rtl/rvfetch_pkg.sv
// rvfetch_pkg: shared types and constants for the rvfetch instruction-fetch stage.
`default_nettype none
package rvfetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

endpackage
`default_nettype wire

// File: rtl/rvifid_reg.sv
// rvifid_reg: IF/ID pipeline register; flush > stall > write > bubble.
`default_nettype none
module rvifid_reg
   import rvfetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        wr_en,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] pcplus4_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic [31:0] pcplus4_out,
   output logic        valid_out
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else if (wr_en) begin
         instr_d   = instr_in;
         pc_d      = pc_in;
         pcplus4_d = pcplus4_in;
         valid_d   = 1'b1;
      end else begin
         // bubble: payload is left as-is, only the valid bit drops
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q   <= 32'h0;
         pc_q      <= 32'h0;
         pcplus4_q <= 32'h0;
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
      end
   end

   assign instr_out   = instr_q;
   assign pc_out      = pc_q;
   assign pcplus4_out = pcplus4_q;
   assign valid_out   = valid_q;

endmodule
`default_nettype wire

// File: rtl/rvfetch.sv
// rvfetch: single-outstanding instruction fetch FSM with redirect, hold buffer and IF/ID register.
`default_nettype none
module rvfetch
   import rvfetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RVPCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   input  logic        FlushD,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemRdy,
   input  logic [31:0] ImemRD,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         req;
   logic         fetch_wr;
   logic [31:0]  fetch_instr;
   logic [31:0]  pc_plus4;

   assign pc_plus4 = pc_q + PC_INCR;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_d       = buf_q;
      req         = 1'b0;
      fetch_wr    = 1'b0;
      fetch_instr = ImemRD;
      case (state_q)
         S_IDLE: begin
            if (!RVPCSrcE) begin
               req     = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (RVPCSrcE) begin
               // a response still in flight must be swallowed in DROP
               state_d = ImemRdy ? S_IDLE : S_DROP;
            end else if (ImemRdy) begin
               if (!StallD) begin
                  fetch_wr = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  buf_d   = ImemRD;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            fetch_instr = buf_q;
            if (RVPCSrcE) begin
               state_d = S_IDLE;
            end else if (!StallD) begin
               fetch_wr = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_DROP: begin
            if (ImemRdy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (RVPCSrcE) begin
         pc_d = PCTargetE;
      end else if (fetch_wr) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         buf_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   assign ImemReq  = req & reset;
   assign ImemAddr = pc_q;
   assign PCF      = pc_q;

   rvifid_reg u_ifid (
      .clk         (clk),
      .reset       (reset),
      .stall       (StallD),
      .flush       (FlushD),
      .wr_en       (fetch_wr),
      .instr_in    (fetch_instr),
      .pc_in       (pc_q),
      .pcplus4_in  (pc_plus4),
      .instr_out   (InstrD),
      .pc_out      (PCD),
      .pcplus4_out (PCPlus4D),
      .valid_out   (ValidD)
   );

endmodule
`default_nettype wire

// File: tb/tb_rvfetch.sv
// tb_rvfetch: directed scenarios plus randomized run against a behavioural fetch model.
`default_nettype none
module tb_rvfetch;

   logic        clk;
   logic        reset;
   logic        RVPCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic        FlushD;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemRdy;
   logic [31:0] ImemRD;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int n_checks = 0;
   int n_pass   = 0;

   rvfetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .RVPCSrcE(RVPCSrcE), .PCTargetE(PCTargetE),
      .StallD(StallD), .FlushD(FlushD), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemRdy(ImemRdy), .ImemRD(ImemRD), .PCF(PCF), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory: one pending response, latency mem_lat (or random when <0)
   bit          mem_pend;
   int          mem_cnt;
   int          mem_lat;
   bit          mem_fixed;
   logic [31:0] mem_fixed_word;
   logic [31:0] mem_word;

   // behavioural model of the fetch stage
   logic [31:0] m_pc;
   bit          m_out, m_doomed, m_held;
   logic [31:0] m_hword;
   bit          m_valid;
   logic [31:0] m_instr, m_pcd, m_pcp4;

   bit          s_req;
   logic [31:0] s_addr;

   function automatic logic [31:0] mem_hash(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_out = 0; m_doomed = 0; m_held = 0; m_hword = 0;
      m_valid = 0; m_instr = 0; m_pcd = 0; m_pcp4 = 0;
   endtask

   task automatic model_step(input bit redir, input logic [31:0] tgt, input bit stall,
                             input bit flush, input bit rdy, input logic [31:0] rd);
      bit          wr = 0;
      logic [31:0] w  = 32'h0;
      if (redir) begin
         if (m_out && !rdy) m_doomed = 1;
         else begin m_out = 0; m_doomed = 0; end
         m_held = 0;
      end else if (m_out) begin
         if (rdy) begin
            m_out = 0;
            if (m_doomed) m_doomed = 0;
            else if (!stall) begin wr = 1; w = rd; end
            else begin m_held = 1; m_hword = rd; end
         end
      end else if (m_held) begin
         if (!stall) begin wr = 1; w = m_hword; m_held = 0; end
      end else begin
         m_out = 1;
      end
      if (flush) m_valid = 0;
      else if (!stall) begin
         if (wr) begin m_valid = 1; m_instr = w; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; end
         else m_valid = 0;
      end
      if (redir) m_pc = tgt;
      else if (wr) m_pc = m_pc + 32'd4;
   endtask

   // one clock: drive memory, sample request at negedge, update memory and model after the edge
   task automatic cycle();
      bit          rdy;
      logic [31:0] rd;
      if (mem_pend && mem_cnt == 0) begin ImemRdy = 1; ImemRD = mem_word; end
      else begin ImemRdy = 0; ImemRD = $urandom; end
      @(negedge clk);
      s_req = ImemReq; s_addr = ImemAddr;
      rdy = ImemRdy; rd = ImemRD;
      @(posedge clk);
      if (rdy) mem_pend = 0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (s_req) begin
         mem_pend = 1;
         mem_cnt  = (mem_lat < 0) ? $urandom_range(0, 2) : mem_lat;
         mem_word = mem_fixed ? mem_fixed_word : mem_hash(s_addr);
      end
      model_step(RVPCSrcE, PCTargetE, StallD, FlushD, rdy, rd);
      #1;
   endtask

   task automatic test_reset();
      reset = 0; RVPCSrcE = 0; PCTargetE = 0; StallD = 0; FlushD = 0;
      ImemRdy = 0; ImemRD = 0; mem_pend = 0; mem_cnt = 0; mem_lat = 0;
      mem_fixed = 0; mem_fixed_word = 0; mem_word = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (PCF !== 32'h0 || ValidD !== 1'b0) $display("FAIL reset_pc_valid got=%h/%b exp=0/0", PCF, ValidD); else n_pass++;
      n_checks++; if ({InstrD, PCD, PCPlus4D} !== 96'h0) $display("FAIL reset_ifid got=%h %h %h exp=0", InstrD, PCD, PCPlus4D); else n_pass++;
      n_checks++; if (ImemReq !== 1'b0) $display("FAIL reset_req got=%b exp=0", ImemReq); else n_pass++;
      reset = 1;
   endtask

   task automatic test_sequential();
      mem_fixed = 1; mem_fixed_word = 32'h0050_0093; mem_lat = 0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_checks++; if (s_req !== 1'b1 || s_addr !== 32'(i * 4)) $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, s_req, s_addr, i * 4); else n_pass++;
         cycle();
         n_checks++; if (ValidD !== 1'b1 || PCD !== 32'(i * 4) || InstrD !== 32'h0050_0093) $display("FAIL seq_ifid%0d got=%b/%h/%h exp=1/%h/00500093", i, ValidD, PCD, InstrD, i * 4); else n_pass++;
         n_checks++; if (PCPlus4D !== 32'(i * 4 + 4)) $display("FAIL seq_pcp4_%0d got=%h exp=%h", i, PCPlus4D, i * 4 + 4); else n_pass++;
      end
   endtask

   task automatic test_stall_hold();
      mem_fixed_word = 32'h0010_0113;
      cycle();
      StallD = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++; if (PCF !== 32'h8 || s_req !== 1'b0) $display("FAIL hold_pcf%0d got=%h/%b exp=8/0", i, PCF, s_req); else n_pass++;
      end
      StallD = 0;
      cycle();
      n_checks++; if (InstrD !== 32'h0010_0113 || PCD !== 32'h8 || ValidD !== 1'b1) $display("FAIL hold_release got=%h/%h/%b exp=00100113/8/1", InstrD, PCD, ValidD); else n_pass++;
      n_checks++; if (PCF !== 32'hC) $display("FAIL hold_pcf_next got=%h exp=c", PCF); else n_pass++;
   endtask

   task automatic test_redirect_wait();
      mem_fixed = 0;
      cycle(); cycle();
      mem_lat = 2;
      cycle();
      n_checks++; if (s_addr !== 32'h10) $display("FAIL rdw_addr got=%h exp=10", s_addr); else n_pass++;
      RVPCSrcE = 1; PCTargetE = 32'h100;
      cycle();
      RVPCSrcE = 0;
      n_checks++; if (PCF !== 32'h100) $display("FAIL rdw_pcf got=%h exp=100", PCF); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_checks++; if (s_req !== 1'b0 || ValidD !== 1'b0) $display("FAIL rdw_drop%0d got=%b/%b exp=0/0", i, s_req, ValidD); else n_pass++;
      end
      mem_lat = 0;
      cycle();
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL rdw_refetch got=%b/%h exp=1/100", s_req, s_addr); else n_pass++;
      cycle();
      n_checks++; if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== mem_hash(32'h100)) $display("FAIL rdw_ifid got=%b/%h/%h exp=1/100/%h", ValidD, PCD, InstrD, mem_hash(32'h100)); else n_pass++;
   endtask

   task automatic test_redirect_ready();
      cycle();
      RVPCSrcE = 1; PCTargetE = 32'h200;
      cycle();
      RVPCSrcE = 0;
      n_checks++; if (ValidD !== 1'b0 || PCF !== 32'h200) $display("FAIL rdr_drop got=%b/%h exp=0/200", ValidD, PCF); else n_pass++;
      cycle();
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) $display("FAIL rdr_refetch got=%b/%h exp=1/200", s_req, s_addr); else n_pass++;
      cycle();
      n_checks++; if (ValidD !== 1'b1 || PCD !== 32'h200) $display("FAIL rdr_ifid got=%b/%h exp=1/200", ValidD, PCD); else n_pass++;
   endtask

   task automatic test_flush_wrap();
      StallD = 1; FlushD = 1;
      cycle();
      StallD = 0; FlushD = 0;
      n_checks++; if (ValidD !== 1'b0 || PCD !== 32'h200) $display("FAIL flush_stall got=%b/%h exp=0/200", ValidD, PCD); else n_pass++;
      RVPCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
      cycle();
      RVPCSrcE = 0;
      cycle();
      n_checks++; if (s_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", s_addr); else n_pass++;
      cycle();
      n_checks++; if (PCF !== 32'h0 || PCPlus4D !== 32'h0 || PCD !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got=%h/%h/%h exp=0/0/fffffffc", PCF, PCPlus4D, PCD); else n_pass++;
   endtask

   task automatic test_async_reset();
      cycle(); cycle();
      cycle();
      #2 reset = 0;
      #1;
      n_checks++; if (PCF !== 32'h0 || ValidD !== 1'b0 || ImemReq !== 1'b0) $display("FAIL areset_now got=%h/%b/%b exp=0/0/0", PCF, ValidD, ImemReq); else n_pass++;
      n_checks++; if ({InstrD, PCD, PCPlus4D} !== 96'h0) $display("FAIL areset_ifid got=%h %h %h exp=0", InstrD, PCD, PCPlus4D); else n_pass++;
      @(posedge clk);
      #1 reset = 1;
      model_reset();
      cycle();
      n_checks++; if (ValidD !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL areset_stale got=%b/%b/%h exp=0/1/0", ValidD, s_req, s_addr); else n_pass++;
      cycle();
      n_checks++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== mem_hash(32'h0)) $display("FAIL areset_fetch got=%b/%h/%h exp=1/0/%h", ValidD, PCD, InstrD, mem_hash(32'h0)); else n_pass++;
   endtask

   task automatic test_random();
      bit          exp_req;
      logic [31:0] exp_addr;
      int          errs = 0;
      mem_lat = -1;
      for (int i = 0; i < 1500; i++) begin
         StallD    = ($urandom % 10) < 3;
         RVPCSrcE  = ($urandom % 12) == 0;
         PCTargetE = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         FlushD    = RVPCSrcE ? 1'($urandom % 2) : (($urandom % 20) == 0);
         exp_req   = !m_out && !m_held && !RVPCSrcE;
         exp_addr  = m_pc;
         cycle();
         n_checks++;
         if (s_req !== exp_req || s_addr !== exp_addr) begin
            if (errs++ < 10) $display("FAIL rnd_req cyc=%0d got=%b/%h exp=%b/%h", i, s_req, s_addr, exp_req, exp_addr);
         end else n_pass++;
         n_checks++;
         if (PCF !== m_pc || ValidD !== m_valid) begin
            if (errs++ < 10) $display("FAIL rnd_pc cyc=%0d got=%h/%b exp=%h/%b", i, PCF, ValidD, m_pc, m_valid);
         end else n_pass++;
         n_checks++;
         if (InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pcp4) begin
            if (errs++ < 10) $display("FAIL rnd_ifid cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, InstrD, PCD, PCPlus4D, m_instr, m_pcd, m_pcp4);
         end else n_pass++;
      end
      StallD = 0; RVPCSrcE = 0; FlushD = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall_hold();
      test_redirect_wait();
      test_redirect_ready();
      test_flush_wrap();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rvfetch.md
RVFETCH -- requirements
Module: rvfetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RVPCSrcE  input  1  redirect request from the execute-stage branch decision.
REQ-005 SHALL have port PCTargetE  input  32  redirect target address.
REQ-006 SHALL have port StallD  input  1  hold IF/ID register.
REQ-007 SHALL have port FlushD  input  1  invalidate IF/ID register.
REQ-008 SHALL have port ImemReq  output  1  one-cycle instruction-memory request strobe.
REQ-009 SHALL have port ImemAddr  output  32  request address; equals PCF.
REQ-010 SHALL have port ImemRdy  input  1  response valid, no earlier than 1 cycle after ImemReq.
REQ-011 SHALL have port ImemRD  input  32  response instruction word.
REQ-012 SHALL have ports PCF out 32; InstrD, PCD, PCPlus4D out 32 each; ValidD out 1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, HOLD, DROP with at most one outstanding request.
REQ-014 IDLE: ImemReq=1 iff RVPCSrcE=0; on request -> WAIT; else stay IDLE.
REQ-015 WAIT, ImemRdy=1, StallD=0, RVPCSrcE=0: write IF/ID (InstrD=ImemRD, PCD=PCF, PCPlus4D=PCF+4, ValidD=1), PCF<=PCF+4, -> IDLE.
REQ-016 WAIT, ImemRdy=1, StallD=1, RVPCSrcE=0: capture ImemRD into 1-entry buffer, PCF unchanged, -> HOLD.
REQ-017 HOLD, StallD=0, RVPCSrcE=0: write IF/ID from buffer per REQ-015, PCF<=PCF+4, -> IDLE.
REQ-018 RVPCSrcE=1 in any state: PCF<=PCTargetE; no IF/ID write from fetch that cycle.
REQ-019 Redirect next state: IDLE->IDLE; WAIT with ImemRdy=1 ->IDLE (response dropped); WAIT with ImemRdy=0 ->DROP; HOLD->IDLE (buffer discarded); DROP->DROP.
REQ-020 DROP, ImemRdy=1: discard response, no IF/ID write, -> IDLE.
REQ-021 IF/ID priority: FlushD (ValidD<=0, data held) > StallD (all held) > fetch write > bubble (ValidD<=0).
REQ-022 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-023 ImemAddr SHALL be PCF combinationally; PCF stable while in WAIT/HOLD/DROP absent redirect.
REQ-024 FlushD with a same-cycle fetch write SHALL discard the fetched word (flush wins; hazard unit asserts FlushD only with RVPCSrcE).

Reset
REQ-025 reset=0 SHALL immediately force PCF=RESET_PC, state=IDLE, ValidD=0, InstrD=PCD=PCPlus4D=0, buffer=0, independent of clk.
REQ-026 Reset mid-request SHALL abandon the outstanding request; any ImemRdy in the first cycle after release while in IDLE SHALL be ignored.
REQ-027 ImemReq SHALL be 0 while reset=0.

Structure
REQ-028 Package rvfetch_pkg SHALL hold the FSM state enum, default RESET_PC, and PC increment constant 4.
REQ-029 IF/ID register with REQ-021 priority SHALL be sub-module rvifid_reg.

Verification
REQ-030 Reset release, RESET_PC=0, ImemRdy 1 cycle after each req with 32'h00500093 -> PCD=0 then 4, ValidD=1 each fetch.
REQ-031 StallD=1 for 3 cycles as response 32'h00100113 arrives -> HOLD, PCF held at 8; InstrD=32'h00100113, PCD=8 cycle after StallD falls.
REQ-032 RVPCSrcE=1, PCTargetE=32'h100 while WAIT at PCF=0x10 -> DROP; late response dropped; next ImemAddr=0x100.
REQ-033 RVPCSrcE=1 same cycle as ImemRdy=1 -> response dropped, state IDLE, ImemAddr=PCTargetE next cycle.
REQ-034 FlushD=1 with StallD=1 -> ValidD=0 next cycle; PCF=32'hFFFF_FFFC fetch -> PCF=0.
REQ-035 reset=0 asserted in WAIT -> outputs at reset values before next clk edge.
